// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and load/store requesters.
// Data wins by default; a run-length counter forces a pending fetch through after DATA_MAX_RUN data grants.
//
//   state | meaning
//   IDLE  | no access in flight, arbitrate every cycle
//   ISSUE | sram_* drive the granted access, owner sees addr_ok
//   RESP  | sram_rdata valid, owner sees data_ok, arbitrate next access
module sram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_MAX_RUN = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int              CNT_W   = $clog2(DATA_MAX_RUN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(DATA_MAX_RUN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner_data;
    logic [CNT_W-1:0]  r_run_cnt;
    logic              r_sram_en;
    logic              r_sram_we;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [31:0]       r_sram_wdata;

    logic w_arb;
    logic w_guard;
    logic w_grant_data;
    logic w_grant_inst;

    assign w_arb        = (r_state == S_IDLE) || (r_state == S_RESP);
    // fetch has waited out a full data run: it takes this slot
    assign w_guard      = inst_req && (r_run_cnt == RUN_MAX);
    assign w_grant_data = w_arb && data_req && !w_guard;
    assign w_grant_inst = w_arb && inst_req && !w_grant_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_owner_data <= 1'b0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_grant_data || w_grant_inst) begin
                        r_state      <= S_ISSUE;
                        r_owner_data <= w_grant_data;
                        r_sram_en    <= 1'b1;
                        r_sram_we    <= w_grant_data && data_wr;
                        r_sram_addr  <= w_grant_data ? data_addr : inst_addr;
                        r_sram_wdata <= w_grant_data ? data_wdata : 32'h0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_state   <= S_RESP;
                    r_sram_en <= 1'b0;
                    r_sram_we <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_sram_en <= 1'b0;
                    r_sram_we <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_run_cnt <= '0;
        end else if (w_grant_data) begin
            r_run_cnt <= inst_req ? (r_run_cnt + CNT_W'(1)) : '0;
        end else if (w_grant_inst) begin
            r_run_cnt <= '0;
        end
    end

    assign inst_addr_ok = (r_state == S_ISSUE) && !r_owner_data;
    assign data_addr_ok = (r_state == S_ISSUE) &&  r_owner_data;
    assign inst_data_ok = (r_state == S_RESP)  && !r_owner_data;
    assign data_data_ok = (r_state == S_RESP)  &&  r_owner_data;
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

    assign sram_en    = r_sram_en;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: queued requesters, a slot-based arbitration model,
// a word-array memory reference, and a monitor that retires expected responses on data_ok.
module tb_sram_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int MAX_RUN = 4;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          gap;
    } txn_t;

    typedef struct {
        bit          is_data;
        bit          is_store;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              inst_req = 1'b0;
    logic [ADDR_W-1:0] inst_addr = '0;
    logic              inst_addr_ok, inst_data_ok;
    logic [31:0]       inst_rdata;
    logic              data_req = 1'b0;
    logic              data_wr = 1'b0;
    logic [ADDR_W-1:0] data_addr = '0;
    logic [31:0]       data_wdata = '0;
    logic              data_addr_ok, data_data_ok;
    logic [31:0]       data_rdata;
    logic              sram_en, sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_MAX_RUN(MAX_RUN)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    function automatic int idx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    // contents of a word never written; 0x1c000000 holds a known instruction
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h1c00_0000) ? 32'h0280_0c0c : (a ^ 32'h5a5a_a5a5);
    endfunction

    logic [31:0] sram_mem [256];
    bit          sram_wr  [256];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                sram_mem[idx(sram_addr)] <= sram_wdata;
                sram_wr[idx(sram_addr)]  <= 1'b1;
            end else begin
                sram_rdata <= sram_wr[idx(sram_addr)] ? sram_mem[idx(sram_addr)] : init_word(sram_addr);
            end
        end
    end

    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];

    txn_t  iq[$];
    txn_t  dq[$];
    resp_t sb[$];
    txn_t  tmp;
    bit    i_started = 0, d_started = 0;
    int    i_gap = 0, d_gap = 0;

    int exp_g = 0;            // 0 none, 1 inst, 2 data: grant expected at the coming edge
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic        exp_we = 1'b0;
    int run_m = 0;
    bit prev_en = 0;
    bit logging = 0;
    int glog[$];
    int gcyc[$];
    int pat [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_i(input logic [31:0] a, input int g);
        tmp.addr = a; tmp.wr = 1'b0; tmp.wdata = '0; tmp.gap = g;
        iq.push_back(tmp);
    endtask

    task automatic push_d(input logic [31:0] a, input logic w, input logic [31:0] wd, input int g);
        tmp.addr = a; tmp.wr = w; tmp.wdata = wd; tmp.gap = g;
        dq.push_back(tmp);
    endtask

    // One cycle of the reference: check the edge just passed, advance requesters, predict the next edge.
    task automatic model_step();
        int    ng;
        resp_t r;
        chk("inst_addr_ok", inst_addr_ok, exp_g == 1);
        chk("data_addr_ok", data_addr_ok, exp_g == 2);
        chk("sram_en", sram_en, exp_g != 0);
        chk("sram_en_gap", prev_en & sram_en, 1'b0);
        prev_en = sram_en;
        if (exp_g != 0) begin
            chk("sram_addr", sram_addr, exp_addr);
            chk("sram_we", sram_we, exp_we);
            chk("sram_wdata", sram_wdata, exp_wdata);
            r.is_data  = (exp_g == 2);
            r.is_store = exp_we;
            r.cyc      = cyc;
            if (exp_we) begin
                ref_mem[idx(exp_addr)] = exp_wdata;
                ref_wr[idx(exp_addr)]  = 1'b1;
                r.rdata = '0;
            end else begin
                r.rdata = ref_wr[idx(exp_addr)] ? ref_mem[idx(exp_addr)] : init_word(exp_addr);
            end
            sb.push_back(r);
        end else begin
            chk("sram_we_quiet", sram_we, 1'b0);
        end
        if (logging && (data_addr_ok || inst_addr_ok)) begin
            glog.push_back(data_addr_ok ? 2 : 1);
            gcyc.push_back(cyc);
        end
        if (inst_addr_ok && iq.size() > 0) begin void'(iq.pop_front()); i_started = 0; end
        if (data_addr_ok && dq.size() > 0) begin void'(dq.pop_front()); d_started = 0; end

        inst_req = 1'b0;
        if (iq.size() > 0) begin
            if (!i_started) begin i_gap = iq[0].gap; i_started = 1; end
            if (i_gap > 0) i_gap--;
            else begin inst_req = 1'b1; inst_addr = iq[0].addr; end
        end
        data_req = 1'b0;
        if (dq.size() > 0) begin
            if (!d_started) begin d_gap = dq[0].gap; d_started = 1; end
            if (d_gap > 0) d_gap--;
            else begin
                data_req = 1'b1; data_addr = dq[0].addr;
                data_wr = dq[0].wr; data_wdata = dq[0].wdata;
            end
        end

        // no grant can land on the edge right after a grant
        if (exp_g != 0) ng = 0;
        else if (data_req && !(inst_req && run_m == MAX_RUN)) ng = 2;
        else if (inst_req) ng = 1;
        else ng = 0;
        if (ng == 2) begin
            run_m = inst_req ? run_m + 1 : 0;
            exp_addr = data_addr; exp_we = data_wr; exp_wdata = data_wdata;
        end else if (ng == 1) begin
            run_m = 0;
            exp_addr = inst_addr; exp_we = 1'b0; exp_wdata = '0;
        end
        exp_g = ng;
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || sb.size() > 0 || exp_g != 0) && n < budget) begin
            @(negedge clk);
            model_step();
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL timeout_%s: still pending after %0d cycles (iq %0d dq %0d sb %0d)",
                     name, budget, iq.size(), dq.size(), sb.size());
        end
        repeat (2) begin @(negedge clk); model_step(); end
    endtask

    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge clk);
            if (inst_data_ok || data_data_ok) begin
                chk("data_ok_excl", inst_data_ok & data_data_ok, 1'b0);
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_data_ok: inst %0b data %0b with nothing outstanding (cycle %0d)",
                             inst_data_ok, data_data_ok, cyc);
                end else begin
                    r = sb.pop_front();
                    chk("resp_owner", data_data_ok, r.is_data);
                    chk("resp_latency", cyc, r.cyc + 1);
                    if (!r.is_store)
                        chk(r.is_data ? "data_rdata" : "inst_rdata",
                            r.is_data ? data_rdata : inst_rdata, r.rdata);
                end
            end else if (sb.size() > 0 && sb[0].cyc + 1 == cyc) begin
                r = sb.pop_front();
                checks++; errors++;
                $display("FAIL missing_data_ok: got none expected %s response (cycle %0d)",
                         r.is_data ? "data" : "inst", cyc);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_sram_en", sram_en, 1'b0);
        chk("rst_sram_we", sram_we, 1'b0);
        chk("rst_sram_addr", sram_addr, 32'h0);
        chk("rst_sram_wdata", sram_wdata, 32'h0);
        chk("rst_ok", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 4'b0);
        resetn = 1'b1;

        push_i(32'h1c00_0000, 0);
        run_until_idle(20, "single_fetch");

        push_d(32'h0000_0100, 1'b1, 32'hdead_beef, 0);
        push_d(32'h0000_0100, 1'b0, 32'h0, 0);
        run_until_idle(20, "store_load");

        push_i(32'h0000_0104, 0);
        push_d(32'h0000_0100, 1'b0, 32'h0, 0);
        run_until_idle(20, "simultaneous");

        logging = 1;
        glog.delete(); gcyc.delete();
        for (int k = 0; k < 10; k++) begin
            push_d(32'h0000_0200 + 32'(k * 4), 1'b0, 32'h0, 0);
            push_i(32'h0000_0300 + 32'(k * 4), 0);
        end
        run_until_idle(100, "starvation");
        logging = 0;
        if (glog.size() < 10) begin
            checks++; errors++;
            $display("FAIL starve_count: got %0d grants expected at least 10", glog.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                chk("starve_order", glog[k], pat[k]);
                if (k > 0) chk("starve_gap", gcyc[k] - gcyc[k-1], 2);
            end
        end

        for (int k = 0; k < 4; k++) push_i(32'h1c00_0000 + 32'(k * 4), 0);
        run_until_idle(40, "b2b_fetch");

        push_d(32'h0000_0208, 1'b0, 32'h0, 0);
        for (int n = 0; n < 10 && !data_addr_ok; n++) begin
            @(negedge clk);
            model_step();
        end
        chk("midop_issue", data_addr_ok, 1'b1);
        #1 resetn = 1'b0;
        #1;
        chk("midop_sram_en", sram_en, 1'b0);
        chk("midop_addr_ok", data_addr_ok, 1'b0);
        sb.delete(); iq.delete(); dq.delete();
        exp_g = 0; run_m = 0; prev_en = 0; i_started = 0; d_started = 0;
        inst_req = 1'b0; data_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midop_no_data_ok", data_data_ok, 1'b0);
        end
        resetn = 1'b1;
        repeat (2) begin @(negedge clk); model_step(); end
        push_i(32'h1c00_0000, 0);
        run_until_idle(20, "post_reset_fetch");

        for (int k = 0; k < 150; k++) begin
            push_i(32'h0000_0200 + 32'($urandom_range(0, 15) * 4), int'($urandom_range(0, 3)));
            push_d(32'h0000_0200 + 32'($urandom_range(0, 15) * 4), 1'($urandom_range(0, 1)),
                   $urandom, int'($urandom_range(0, 3)));
        end
        run_until_idle(5000, "random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one synchronous single-port SRAM between the CPU's instruction-fetch requester and its load/store requester. Each transaction uses an addr_ok/data_ok handshake. Data accesses win by default, but a run-length counter stops continuous data traffic from starving fetch indefinitely. The block sits between the CPU core's fetch/memory stages and the unified SRAM.

## Interface
Parameters:
- ADDR_W, 32, width of SRAM address and requester addresses
- DATA_MAX_RUN, 4, maximum consecutive data grants while inst_req is pending before inst is forced through (≥1)

Ports:
- clk  in  1  single clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok seen
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  one-cycle pulse: fetch accepted, issued to SRAM this cycle
- inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
- inst_rdata  out  32  fetch read data (valid only with inst_data_ok)
- data_req  in  1  load/store request; held with data_wr, data_addr, data_wdata until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  32  store data
- data_addr_ok  out  1  one-cycle pulse: data request accepted and issued
- data_data_ok  out  1  one-cycle pulse: load data valid, or store complete
- data_rdata  out  32  load data (valid only with data_data_ok)
- sram_en  out  1  SRAM access enable (registered)
- sram_we  out  1  SRAM write enable (registered)
- sram_addr  out  ADDR_W  SRAM address (registered)
- sram_wdata  out  32  SRAM write data (registered)
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- Arbitration happens on the clock edge leaving IDLE or RESP. It uses the req inputs sampled in that cycle:
  - data_req only → grant data.
  - inst_req only → grant inst.
  - Both → grant data, unless run_cnt == DATA_MAX_RUN; then grant inst.
  - Neither → go to IDLE.
- On a grant:
  - Go to ISSUE.
  - Register sram_en=1, sram_we=(data grant & data_wr), sram_addr=granted addr, sram_wdata=data_wdata (0 for inst).
  - Record the grant owner.
- ISSUE:
  - sram_* registers drive the access.
  - The owner's addr_ok = 1.
  - Requests are ignored.
  - Next state is RESP. sram_en and sram_we clear at this edge.
- RESP:
  - The owner's data_ok = 1.
  - inst_rdata/data_rdata = sram_rdata, passed straight through on both outputs.
  - Stores also pulse data_data_ok here.
  - Arbitrate for the next transaction.
- run_cnt (width clog2(DATA_MAX_RUN+1)):
  - Data grant with inst_req = 1 → +1.
  - Data grant with inst_req = 0 → cleared.
  - Inst grant → cleared.
  - Never exceeds DATA_MAX_RUN.
- A requester must not change its address or data between asserting req and seeing addr_ok. Dropping req before addr_ok means no grant is issued for it; this is legal.
- A requester re-asserting req during its own RESP cycle may be re-granted immediately.

## Timing
- Reset, asynchronous: state=IDLE, run_cnt=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, all addr_ok/data_ok=0.
  - A transaction in flight is discarded. No data_ok is ever produced for it.
  - Requests are evaluated from the first edge after resetn rises.
- Latency: req high in cycle N (FSM in IDLE) → addr_ok and sram_en in N+1 → data_ok and rdata in N+2.
- Throughput: one transaction per 2 cycles when requests are continuous (RESP→ISSUE directly).
- addr_ok and data_ok are never high for both requesters in the same cycle. Each is exactly one cycle wide per transaction.
- sram_en is never high in two consecutive cycles.

## Test plan
- Single fetch: inst_req=1, inst_addr=0x1c000000 in IDLE, SRAM holding 0x02800c0c → inst_addr_ok at +1 with sram_addr=0x1c000000 and sram_we=0; inst_data_ok at +2 with inst_rdata=0x02800c0c.
- Store then load: data store to 0x100 with wdata 0xdeadbeef, then load from 0x100 → sram_we=1 only in the store's ISSUE cycle; store data_data_ok 2 cycles after grant; load returns 0xdeadbeef.
- Simultaneous: inst_req and data_req both high in IDLE with run_cnt=0 → data granted first; inst granted in the data RESP cycle; inst_addr_ok appears 2 cycles after data_addr_ok.
- Starvation guard: data_req and inst_req held high continuously, DATA_MAX_RUN=4 → grant order D,D,D,D,I,D,D,D,D,I, each grant 2 cycles apart.
- Back-to-back fetch: inst_req held high over 4 transactions → inst_addr_ok every 2 cycles; sram_en never high in consecutive cycles.
- Reset mid-op: assert resetn=0 during ISSUE of a load → sram_en drops to 0 immediately; no data_data_ok appears; after release, a new fetch completes with normal +1/+2 latency.
